// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin, packet-atomic arbiter sharing the single write port of the
//   async FIFO among NREQ requesters in the wclk domain. Once a requester is
//   granted it owns the port until a beat marked last is written.
//   A bubble (IDLE) cycle always separates packets. wfull back-pressures the
//   granted requester combinationally, so winc is never raised into a full FIFO.
//
// Ports
//   wclk, wrst_n          write clock, async active-low reset
//   req_valid/last/data   per-requester beat; lane i data at [i*DATA +: DATA]
//   req_ready             per-requester beat accepted this cycle
//   wfull                 FIFO full (registered in wclk domain)
//   winc, wdata           FIFO write enable / data
//   grant                 registered one-hot owner, zero when idle
//   busy                  packet in progress
//   timeout_err           (ARB_TIMEOUT_EN only) one-cycle pulse when an idle
//                         owner loses the grant
//
// Build option
//   `define ARB_TIMEOUT_EN  adds an idle counter. A granted requester that
//   shows no valid for TIMEOUT cycles (wfull stalls excluded) is dropped.
//   Without it, an owner may hold the port forever.

// Per-lane slice: ready/transfer qualification and AND-masked data, so the
// top level can OR-reduce lane data into wdata (grant is one-hot or zero).
module fifo_wr_arbiter_lane #(
  parameter int DATA = 8
) (
  input  logic            gnt_i,
  input  logic            valid_i,
  input  logic            last_i,
  input  logic [DATA-1:0] data_i,
  input  logic            wfull_i,
  output logic            ready_o,
  output logic            xfer_o,
  output logic            eop_o,
  output logic [DATA-1:0] data_o
);
  assign ready_o = gnt_i & ~wfull_i;
  assign xfer_o  = ready_o & valid_i;
  assign eop_o   = xfer_o & last_i;
  // Holds the granted lane's data even when no beat moves.
  assign data_o  = gnt_i ? data_i : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DATA    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*DATA-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wfull,
  output logic                 winc,
  output logic [DATA-1:0]      wdata,
  output logic [NREQ-1:0]      grant,
  output logic                 busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  localparam int IDXW = $clog2(NREQ);

  // Reject configurations the round-robin scan and counter are not sized for.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [NREQ-1:0]          grant_q, grant_d;
  logic [IDXW-1:0]          rr_q, rr_d;

  logic [NREQ-1:0]          lane_ready, lane_xfer, lane_eop;
  logic [NREQ-1:0][DATA-1:0] lane_data;

  logic                     win_found;
  logic [IDXW-1:0]          win_idx;
  logic                     xfer, eop;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     tmo_q, tmo_d;
  logic                     g_valid;

  assign g_valid = |(req_valid & grant_q);
`endif

  // ---------------------------------------------------------------- lanes
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.DATA(DATA)) u_lane (
      .gnt_i   (grant_q[i]),
      .valid_i (req_valid[i]),
      .last_i  (req_last[i]),
      .data_i  (req_data[i*DATA +: DATA]),
      .wfull_i (wfull),
      .ready_o (lane_ready[i]),
      .xfer_o  (lane_xfer[i]),
      .eop_o   (lane_eop[i]),
      .data_o  (lane_data[i])
    );
  end

  assign xfer = |lane_xfer;
  assign eop  = |lane_eop;

  // Round-robin scan: first valid requester after rr_q, wrapping modulo NREQ.
  // The last slot checked is rr_q itself, so the previous owner ranks lowest.
  always_comb begin
    logic [IDXW-1:0] j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = IDXW'((int'(rr_q) + k) % NREQ);
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = j;
      end
    end
  end

  // ---------------------------------------------------------- state register
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= IDXW'(NREQ - 1);
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // ------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // No beat is taken here; the grant lands on this edge and data
        // starts flowing the cycle after.
        if (win_found) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          rr_d             = win_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d            = '0;
`endif
        end
      end
      GRANT: begin
        // Grant only moves at end-of-packet (or on timeout), never mid-packet.
        if (eop) begin
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (xfer) begin
          cnt_d = '0;
        end else if (!g_valid) begin
          // Owner idle: count toward the drop. A wfull stall with valid high
          // takes neither branch and leaves the count alone.
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    busy      = (state_q == GRANT);
    // grant_q is zero in IDLE, so no lane can be ready there.
    req_ready = lane_ready;
    winc      = xfer;
    wdata     = '0;
    for (int i = 0; i < NREQ; i++) begin
      wdata = wdata | lane_data[i];
    end
  end

  assign grant = grant_q;

`ifdef ARB_TIMEOUT_EN
  assign timeout_err = tmo_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DATA = 8;

  logic                 wclk = 1'b0;
  logic                 wrst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ*DATA-1:0] req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 wfull = 1'b0;
  logic                 winc;
  logic [DATA-1:0]      wdata;
  logic [NREQ-1:0]      grant;
  logic                 busy;
`ifdef ARB_TIMEOUT_EN
  logic                 timeout_err;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA(DATA), .TIMEOUT(15)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
    .busy      (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [DATA-1:0] d;
    logic            l;
  } beat_t;

  beat_t stim[NREQ][$];   // what each requester still has to send
  beat_t expq[NREQ][$];   // scoreboard: beats the FIFO must still receive
  int    won[$];          // arbitration winners, in order

  int total = 0, passed = 0;

  // Reference model: who owns the port, and the last winner.
  bit m_idle = 1'b1;
  int m_own  = 0;
  int m_rr   = NREQ - 1;

  logic [NREQ-1:0] hs = '0;
  logic [NREQ-1:0] hold = '0;
  bit rnd_mode = 1'b0, wfull_force = 1'b0, chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic push_pkt(input int r, input int n, input logic [DATA-1:0] d0,
                          input logic [DATA-1:0] step);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = d0 + DATA'(k) * step;
      b.l = (k == n - 1);
      stim[r].push_back(b);
      expq[r].push_back(b);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wclk);
      #2;
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (stim[i].size() != 0) p = 1'b1;
    return p || !m_idle;
  endfunction

  task automatic wait_idle(input string nm);
    int c = 0;
    while (pending() && c < 3000) begin
      tick(1);
      c++;
    end
    if (c >= 3000) begin
      total++;
      $display("FAIL %s: still busy after 3000 cycles, idle required", nm);
    end
    tick(1);
  endtask

  // Requester driver: present the head beat, pop it once accepted.
  always @(posedge wclk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i] && stim[i].size() != 0) void'(stim[i].pop_front());
      if (stim[i].size() != 0) begin
        req_valid[i] = !hold[i] && (!rnd_mode || $urandom_range(3) != 0);
        req_data[i*DATA +: DATA] = stim[i][0].d;
        req_last[i] = stim[i][0].l;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DATA +: DATA] = '0;
      end
    end
    hs = '0;
    wfull = rnd_mode ? ($urandom_range(4) == 0) : wfull_force;
  end

  // Monitor: compare outputs to the model mid-cycle, then advance the model.
  always @(negedge wclk) begin
    logic [NREQ-1:0] eg;
    logic            ew;
    beat_t           b;
    bit              found;
    int              j;
    if (wrst_n && chk_en) begin
      eg = '0;
      if (!m_idle) eg[m_own] = 1'b1;
      ew = !m_idle && req_valid[m_own] && !wfull;
      chk("grant", grant, eg);
      chk("busy", busy, !m_idle);
      chk("winc", winc, ew);
      chk("req_ready", req_ready, wfull ? '0 : eg);
      chk("wdata", wdata, m_idle ? '0 : req_data[m_own*DATA +: DATA]);
      chk("winc_and_wfull", winc & wfull, 0);
      if (ew) begin
        if (expq[m_own].size() == 0) begin
          total++;
          $display("FAIL beat_extra: req%0d wrote %0h, no beat expected", m_own, wdata);
        end else begin
          b = expq[m_own].pop_front();
          chk($sformatf("beat_req%0d", m_own), {wdata, req_last[m_own]}, b);
        end
      end
      hs = req_valid & req_ready;
      if (m_idle) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          j = (m_rr + k) % NREQ;
          if (!found && req_valid[j]) begin
            found  = 1'b1;
            m_own  = j;
            m_rr   = j;
            m_idle = 1'b0;
            won.push_back(j);
          end
        end
      end else if (ew && req_last[m_own]) begin
        m_idle = 1'b1;
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge wclk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_winc", winc, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wdata", wdata, 0);
    @(negedge wclk);
    wrst_n = 1'b1;
    chk_en = 1'b1;
    tick(2);

    // 1: four single-beat packets -> 0,1,2,3
    won.delete();
    for (int i = 0; i < NREQ; i++) push_pkt(i, 1, DATA'(8'hA0 + i), 8'h00);
    wait_idle("t1");
    chk("t1_nwon", won.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_order%0d", i), won[i], i);

    // 2: req1 4-beat packet with req0/req2 waiting; req2 wins next
    won.delete();
    push_pkt(0, 1, 8'h5A, 8'h00);
    wait_idle("t2a");
    push_pkt(1, 4, 8'h11, 8'h11);
    push_pkt(0, 1, 8'h70, 8'h00);
    push_pkt(2, 1, 8'h72, 8'h00);
    wait_idle("t2");
    chk("t2_nwon", won.size(), 4);
    chk("t2_first", won[1], 1);
    chk("t2_next", won[2], 2);
    chk("t2_last", won[3], 0);

    // 3: wfull for 5 cycles mid-packet of req0
    push_pkt(0, 6, 8'h30, 8'h01);
    tick(3);
    wfull_force = 1'b1;
    tick(1);
    repeat (5) begin
      @(negedge wclk);
      chk("t3_grant", grant, 4'b0001);
      chk("t3_winc", winc, 0);
      chk("t3_ready", req_ready, 0);
    end
    wfull_force = 1'b0;
    wait_idle("t3");

    // 4: owner drops valid for 3 cycles mid-packet
    push_pkt(2, 5, 8'h40, 8'h01);
    tick(3);
    hold[2] = 1'b1;
    tick(1);
    repeat (3) begin
      @(negedge wclk);
      chk("t4_grant", grant, 4'b0100);
      chk("t4_winc", winc, 0);
    end
    hold[2] = 1'b0;
    wait_idle("t4");

    // 5: reset while req3 owns the port
    push_pkt(3, 5, 8'h50, 8'h01);
    tick(3);
    @(negedge wclk);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_winc", winc, 0);
    for (int i = 0; i < NREQ; i++) begin
      stim[i].delete();
      expq[i].delete();
    end
    hs = '0;
    m_idle = 1'b1;
    m_rr = NREQ - 1;
    @(negedge wclk);
    #2;
    wrst_n = 1'b1;
    tick(1);
    won.delete();
    push_pkt(3, 1, 8'h63, 8'h00);
    push_pkt(0, 1, 8'h60, 8'h00);
    wait_idle("t5");
    chk("t5_nwon", won.size(), 2);
    chk("t5_first", won[0], 0);
    chk("t5_second", won[1], 3);

    // 6: randomized traffic and back-pressure
    rnd_mode = 1'b1;
    repeat (10000) begin
      tick(1);
      for (int i = 0; i < NREQ; i++)
        if (stim[i].size() < 4 && $urandom_range(5) == 0)
          push_pkt(i, $urandom_range(1, 4), DATA'($urandom), DATA'($urandom_range(1, 255)));
    end
    rnd_mode = 1'b0;
    wait_idle("t6");
    for (int i = 0; i < NREQ; i++) chk($sformatf("t6_drain%0d", i), expq[i].size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-atomic arbiter that shares the single write port of the async FIFO among NREQ write-clock-domain requesters.
- Drives the FIFO write enable (winc) and write data, and back-pressures requesters from wfull.
- Sits entirely in the wclk domain, directly upstream of the FIFO write-pointer/full logic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA, 8, data width per beat.
- TIMEOUT, 15, idle-cycle limit for a granted requester; used only with the optional feature; counter width is $clog2(TIMEOUT+1).

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester beat valid.
- req_last  in  NREQ  per-requester end-of-packet marker, qualified by req_valid.
- req_data  in  NREQ*DATA  packed data; requester i occupies bits [i*DATA +: DATA].
- req_ready  out  NREQ  per-requester beat accepted this cycle.
- wfull  in  1  FIFO full flag, registered in the wclk domain.
- winc  out  1  FIFO write enable.
- wdata  out  DATA  FIFO write data.
- grant  out  NREQ  one-hot registered grant; all zero when idle.
- busy  out  1  a packet is in progress (state == GRANT).

Behaviour:
- Reset values (async on wrst_n low):
  - state = IDLE, grant = 0, busy = 0, winc = 0, req_ready = 0.
  - Round-robin pointer rr_last = NREQ-1, so requester 0 has top priority first.
- States:
  - IDLE -> GRANT when any req_valid is high. The winner is the first valid requester scanning rr_last+1, rr_last+2, ... modulo NREQ.
  - On that edge: grant <= onehot(winner), rr_last <= winner.
  - Arbitration latency is 1 cycle; no beat is accepted while in IDLE.
- In GRANT, for granted index g:
  - req_ready[g] = ~wfull (combinational); all other req_ready bits are 0.
  - A beat transfers when req_valid[g] & ~wfull.
  - winc = req_valid[g] & ~wfull; wdata = req_data[g] (combinational mux).
  - Outside a transfer, wdata is don't-care but must hold the granted lane's data; in IDLE it is 0.
- Packet end: a transfer with req_last[g] = 1 gives GRANT -> IDLE next edge with grant <= 0. There is always one bubble cycle between packets.
- Packet atomicity: grant never moves mid-packet, regardless of other requests or wfull.
- wfull high: winc = 0 and req_ready = 0. State and grant hold; there is no limit on the stall length.
- winc must never be high while wfull is high. This is required because the FIFO drops writes when full, and the arbiter must not lose beats.
- req_valid[g] deasserting mid-packet: grant holds, no transfer occurs, state holds.
- Single-beat packet (valid and last together): 1 transfer, then back to IDLE.
- Requester invariants: a requester is assumed to hold req_data/req_last stable while valid and not ready; the arbiter does not register data.
- Reset asserted mid-packet: returns to IDLE immediately and the partial packet is abandoned; the FIFO side resets separately.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An idle counter clears on each transfer and on entering GRANT.
  - It increments each GRANT cycle where req_valid[g] = 0. wfull stalls do not count.
  - When the counter reaches TIMEOUT, the grant is dropped (GRANT -> IDLE, grant <= 0).
  - Extra output port timeout_err (1 bit, reset 0) pulses high for 1 cycle on that edge.
  - rr_last keeps the timed-out index, so it gets lowest priority next.
- Not defined: no counter and no timeout_err port; a granted requester may hold the port indefinitely.

Test Plan:
- Reset then all four requesters present a 1-beat packet -> grants in order 0,1,2,3. Each grant is 1 cycle after IDLE, and winc pulses once per grant with the correct wdata (e.g. 8'hA0..8'hA3).
- Req1 sends a 4-beat packet (11,22,33,44) while req0 and req2 are valid throughout -> all 4 beats land on winc contiguously with grant = 4'b0010; next winner is req2, not req0.
- wfull asserted for 5 cycles mid-packet of req0 -> winc = 0 and req_ready = 0 for those cycles; grant is unchanged; the remaining beats resume in order with no loss or duplication.
- Requester drops req_valid for 3 cycles mid-packet without timeout -> grant holds and the packet completes. With ARB_TIMEOUT_EN and TIMEOUT = 2, the grant is dropped, timeout_err pulses once, and busy = 0.
- wrst_n pulsed low while req3 is in GRANT -> grant = 0, busy = 0, winc = 0 immediately. After release, req0 wins first.
- Randomized valid/last/wfull run over 10k cycles -> a scoreboard per requester sees every beat exactly once, in order and packet-contiguous, and winc & wfull is never observed.
